// File: rtl/mul_booth_iter_if.sv
// Request/response bundle for mul_booth_iter: operand handshake, flush and product handshake.
interface mul_booth_iter_if;
  logic        mul_valid;
  logic        mul_ready;
  logic        mul_signed;
  logic [63:0] multiplicand;
  logic [63:0] multiplier;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result_hi;
  logic [63:0] result_lo;

  modport master (
    output mul_valid, mul_signed, multiplicand, multiplier, flush, out_ready,
    input  mul_ready, out_valid, result_hi, result_lo
  );

  modport slave (
    input  mul_valid, mul_signed, multiplicand, multiplier, flush, out_ready,
    output mul_ready, out_valid, result_hi, result_lo
  );
endinterface

// File: rtl/mul_booth_iter.sv
// Iterative radix-4 Booth multiplier, 64x64 -> 128, signed or unsigned, one Booth digit per cycle.
// Optional macro MUL_EARLY_EXIT_EN ends the run once the remaining Booth digits are all zero.
module mul_booth_iter (
  input logic           clk,
  input logic           rst,
  mul_booth_iter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [127:0]  x_reg;
  logic [127:0]  acc;
  logic [127:0]  pp;
  logic [127:0]  acc_sum;
  logic [66:0]   sr;
  logic [66:0]   sr_shift;
  logic [5:0]    count;
  logic [63:0]   res_hi;
  logic [63:0]   res_lo;
  logic          accept;
  logic          last;
  logic [1:0]    ext2;

  assign ext2     = bus.mul_signed ? {2{bus.multiplier[63]}} : 2'b00;
  assign sr_shift = {{2{sr[66]}}, sr[66:2]};
  assign acc_sum  = acc + pp;

`ifdef MUL_EARLY_EXIT_EN
  // All-zero or all-one remainder recodes to zero digits, so the sum is already final.
  assign last = (count == 6'd32) || (sr_shift == 67'd0) || (&sr_shift);
`else
  assign last = (count == 6'd32);
`endif

  always_comb begin
    pp = 128'd0;
    case (sr[2:0])
      3'b001, 3'b010: pp = x_reg;
      3'b011:         pp = x_reg << 1;
      3'b100:         pp = ~(x_reg << 1) + 128'd1;
      3'b101, 3'b110: pp = ~x_reg + 128'd1;
      default:        pp = 128'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    if (bus.flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.mul_valid) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
        BUSY: if (last) state_next = DONE;
        DONE: if (bus.out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      x_reg  <= 128'd0;
      acc    <= 128'd0;
      sr     <= 67'd0;
      count  <= 6'd0;
      res_hi <= 64'd0;
      res_lo <= 64'd0;
    end else if (accept) begin
      x_reg <= bus.mul_signed ? {{64{bus.multiplicand[63]}}, bus.multiplicand}
                              : {64'd0, bus.multiplicand};
      sr    <= {ext2, bus.multiplier, 1'b0};
      acc   <= 128'd0;
      count <= 6'd0;
    end else if (state == BUSY) begin
      acc   <= acc_sum;
      x_reg <= x_reg << 2;
      sr    <= sr_shift;
      count <= count + 6'd1;
      if (last) {res_hi, res_lo} <= acc_sum;
    end
  end

  assign bus.mul_ready = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result_hi = res_hi;
  assign bus.result_lo = res_lo;

endmodule

// File: tb/tb_mul_booth_iter.sv
// Self-checking bench for mul_booth_iter: scoreboard of expected products, per-scenario tasks.
module tb_mul_booth_iter;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [127:0] sb[$];

  mul_booth_iter_if bus();

  mul_booth_iter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: extend both operands to 128 bits and multiply modulo 2^128.
  function automatic logic [127:0] model(input logic [63:0] x, input logic [63:0] y, input logic s);
    logic [127:0] xe;
    logic [127:0] ye;
    xe = s ? {{64{x[63]}}, x} : {64'd0, x};
    ye = s ? {{64{y[63]}}, y} : {64'd0, y};
    return xe * ye;
  endfunction

  function automatic bit lat_ok(input int n, input int max_lat);
`ifdef MUL_EARLY_EXIT_EN
    return (n >= 1) && (n <= max_lat);
`else
    return (n == 33);
`endif
  endfunction

  task automatic send(input logic [63:0] x, input logic [63:0] y, input logic s);
    bus.multiplicand = x;
    bus.multiplier   = y;
    bus.mul_signed   = s;
    bus.mul_valid    = 1'b1;
    tick();
    bus.mul_valid    = 1'b0;
  endtask

  task automatic wait_out_valid(input string name, output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (bus.out_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: out_valid=%b after %0d cycles, required 1", name, bus.out_valid, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.mul_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_mul_ready: got %b, required 1", bus.mul_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
    checks++;
    if ({bus.result_hi, bus.result_lo} !== 128'd0) begin
      errors++; $display("[TB] FAIL reset_result: got %h, required 0", {bus.result_hi, bus.result_lo});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int n;
    logic [127:0] exp;
    bus.out_ready = 1'b1;
    sb.push_back(128'h0F);
    send(64'd3, 64'd5, 1'b0);
    checks++;
    if (bus.mul_ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_ready: got %b, required 0", bus.mul_ready); end
    wait_out_valid("basic", n);
    if (bus.out_valid === 1'b1) begin
      checks++;
      if (!lat_ok(n, 33)) begin errors++; $display("[TB] FAIL basic_latency: got %0d, required 33", n); end
      exp = sb.pop_front();
      checks++;
      if ({bus.result_hi, bus.result_lo} !== exp) begin
        errors++; $display("[TB] FAIL basic_result: got %h, required %h", {bus.result_hi, bus.result_lo}, exp);
      end
      checks++;
      if (bus.mul_ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_ready: got %b, required 0", bus.mul_ready); end
    end
    tick();
    checks++;
    if (bus.mul_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_return_idle: ready=%b valid=%b, required 1/0", bus.mul_ready, bus.out_valid);
    end
  endtask

  typedef struct {
    logic [63:0]  x;
    logic [63:0]  y;
    logic         s;
    logic [127:0] p;
    int           max_lat;
  } vec_t;

  task automatic test_corners();
    vec_t vecs[4];
    int n;
    logic [127:0] exp;
    vecs[0] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
                128'h4000_0000_0000_0000_0000_0000_0000_0000, 33};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 33};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 128'd1, 33};
    vecs[3] = '{64'd12345, 64'd2, 1'b0, 128'd24690, 3};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(vecs[i].p);
      send(vecs[i].x, vecs[i].y, vecs[i].s);
      wait_out_valid("corner", n);
      if (bus.out_valid === 1'b1) begin
        checks++;
        if (!lat_ok(n, vecs[i].max_lat)) begin
          errors++; $display("[TB] FAIL corner%0d_latency: got %0d, limit %0d", i, n, vecs[i].max_lat);
        end
        exp = sb.pop_front();
        checks++;
        if ({bus.result_hi, bus.result_lo} !== exp) begin
          errors++; $display("[TB] FAIL corner%0d_result: got %h, required %h", i, {bus.result_hi, bus.result_lo}, exp);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    int n;
    logic [63:0] x;
    logic [63:0] y;
    logic s;
    logic [127:0] exp;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      if (i == 0) y = 64'd0;
      s = i[0];
      sb.push_back(model(x, y, s));
      send(x, y, s);
      wait_out_valid("random", n);
      if (bus.out_valid === 1'b1) begin
        exp = sb.pop_front();
        checks++;
        if ({bus.result_hi, bus.result_lo} !== exp) begin
          errors++; $display("[TB] FAIL random%0d_result: got %h, required %h", i, {bus.result_hi, bus.result_lo}, exp);
        end
      end
      tick();
    end
  endtask

  task automatic test_operand_hold();
    int n;
    logic [127:0] exp;
    bus.out_ready = 1'b1;
    sb.push_back(model(64'hDEAD_BEEF_0123_4567, 64'hF000_0000_0000_0003, 1'b1));
    send(64'hDEAD_BEEF_0123_4567, 64'hF000_0000_0000_0003, 1'b1);
    bus.multiplicand = 64'h1111_2222_3333_4444;
    bus.multiplier   = 64'h5555_6666_7777_8888;
    bus.mul_signed   = 1'b0;
    wait_out_valid("hold", n);
    if (bus.out_valid === 1'b1) begin
      exp = sb.pop_front();
      checks++;
      if ({bus.result_hi, bus.result_lo} !== exp) begin
        errors++; $display("[TB] FAIL hold_result: got %h, required %h", {bus.result_hi, bus.result_lo}, exp);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    logic [127:0] exp;
    bus.out_ready = 1'b0;
    sb.push_back(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFD6);
    send(64'hFFFF_FFFF_FFFF_FFF9, 64'd6, 1'b1);
    wait_out_valid("backpressure", n);
    if (bus.out_valid === 1'b1) begin
      exp = sb.pop_front();
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (bus.out_valid !== 1'b1 || {bus.result_hi, bus.result_lo} !== exp || bus.mul_ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL stall%0d: valid=%b ready=%b result=%h, required 1/0/%h",
                   i, bus.out_valid, bus.mul_ready, {bus.result_hi, bus.result_lo}, exp);
        end
        bus.multiplicand = {$urandom, $urandom};
        bus.mul_valid    = 1'b1;
        tick();
      end
    end
    bus.mul_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.mul_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL stall_release: ready=%b valid=%b, required 1/0", bus.mul_ready, bus.out_valid);
    end
  endtask

  task automatic test_flush();
    int n;
    logic [127:0] exp;
    bus.out_ready = 1'b1;
    send(64'd1000, 64'd2000, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    bus.flush        = 1'b1;
    bus.mul_valid    = 1'b1;
    bus.multiplicand = 64'hFFFF_FFFF_FFFF_FF00;
    bus.multiplier   = 64'd77;
    bus.mul_signed   = 1'b1;
    tick();
    checks++;
    if (bus.mul_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_idle: ready=%b valid=%b, required 1/0", bus.mul_ready, bus.out_valid);
    end
    bus.flush = 1'b0;
    sb.push_back(model(64'hFFFF_FFFF_FFFF_FF00, 64'd77, 1'b1));
    tick();
    bus.mul_valid = 1'b0;
    checks++;
    if (bus.mul_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_reaccept: ready=%b, required 0", bus.mul_ready); end
    wait_out_valid("flush", n);
    if (bus.out_valid === 1'b1) begin
      checks++;
      if (!lat_ok(n, 33)) begin errors++; $display("[TB] FAIL flush_latency: got %0d, required 33", n); end
      exp = sb.pop_front();
      checks++;
      if ({bus.result_hi, bus.result_lo} !== exp) begin
        errors++; $display("[TB] FAIL flush_result: got %h, required %h", {bus.result_hi, bus.result_lo}, exp);
      end
    end
    tick();
    bus.out_ready = 1'b0;
    send(64'd9, 64'd9, 1'b0);
    wait_out_valid("flush_done", n);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.mul_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL flush_in_done: valid=%b ready=%b, required 0/1", bus.out_valid, bus.mul_ready);
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n;
    bus.out_ready = 1'b0;
    send(64'h1234, 64'h5678, 1'b0);
    wait_out_valid("reset_done", n);
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    bus.mul_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.flush     = 1'b0;
    bus.mul_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.mul_ready !== 1'b1 || {bus.result_hi, bus.result_lo} !== 128'd0) begin
      errors++;
      $display("[TB] FAIL reset_in_done: valid=%b ready=%b result=%h, required 0/1/0",
               bus.out_valid, bus.mul_ready, {bus.result_hi, bus.result_lo});
    end
    send(64'd555, 64'd777, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    bus.mul_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.mul_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.mul_ready !== 1'b1 || {bus.result_hi, bus.result_lo} !== 128'd0) begin
      errors++;
      $display("[TB] FAIL reset_in_busy: valid=%b ready=%b result=%h, required 0/1/0",
               bus.out_valid, bus.mul_ready, {bus.result_hi, bus.result_lo});
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [127:0] exp;
    bus.out_ready = 1'b1;
    sb.push_back(model(64'h0000_0000_FFFF_0001, 64'h0000_0001_0000_0003, 1'b0));
    sb.push_back(model(64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1));
    send(64'h0000_0000_FFFF_0001, 64'h0000_0001_0000_0003, 1'b0);
    bus.multiplicand = 64'h8000_0000_0000_0001;
    bus.multiplier   = 64'h7FFF_FFFF_FFFF_FFFF;
    bus.mul_signed   = 1'b1;
    bus.mul_valid    = 1'b1;
    wait_out_valid("b2b_first", n);
    if (bus.out_valid === 1'b1) begin
      exp = sb.pop_front();
      checks++;
      if ({bus.result_hi, bus.result_lo} !== exp || bus.mul_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_first: result=%h ready=%b, required %h/0", {bus.result_hi, bus.result_lo}, bus.mul_ready, exp);
      end
    end
    tick();
    checks++;
    if (bus.mul_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_handoff_ready: got %b, required 1", bus.mul_ready); end
    tick();
    bus.mul_valid = 1'b0;
    wait_out_valid("b2b_second", n);
    if (bus.out_valid === 1'b1) begin
      checks++;
      if (!lat_ok(n, 33)) begin errors++; $display("[TB] FAIL b2b_latency: got %0d, required 33", n); end
      exp = sb.pop_front();
      checks++;
      if ({bus.result_hi, bus.result_lo} !== exp) begin
        errors++; $display("[TB] FAIL b2b_second: got %h, required %h", {bus.result_hi, bus.result_lo}, exp);
      end
    end
    tick();
  endtask

  initial begin
    rst              = 1'b1;
    bus.mul_valid    = 1'b0;
    bus.mul_signed   = 1'b0;
    bus.multiplicand = 64'd0;
    bus.multiplier   = 64'd0;
    bus.flush        = 1'b0;
    bus.out_ready    = 1'b0;
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_operand_hold();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_drain: %0d left, required 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
